// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 slice: register numbers and exception codes.
package cp0_pkg;

  localparam logic [4:0] CP0_BADV    = 5'd8;
  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Address-error exceptions are the only causes that capture BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: prescaled up-counter with a sticky match flag cleared by Compare writes.
module cp0_timer
  import cp0_pkg::*;
#(
  parameter int COUNT_DIV = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_count,
  input  logic        wr_compare,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        pending
);

  localparam int DW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(COUNT_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          pend_q, pend_d;
  logic          tick;
  logic [31:0]   count_inc;

  always_comb begin
    tick      = (div_q == DIV_MAX);
    count_inc = count_q + 32'd1;
    div_d     = tick ? '0 : div_q + DW'(1);
    count_d   = tick ? count_inc : count_q;
    compare_d = compare_q;
    pend_d    = pend_q;
    if (tick && (count_inc == compare_q)) pend_d = 1'b1;
    // A software Count write never raises the flag, even if it lands on Compare.
    if (wr_count) begin
      count_d = wr_data;
      div_d   = '0;
      pend_d  = pend_q;
    end
    if (wr_compare) begin
      compare_d = wr_data;
      pend_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= '0;
      count_q   <= 32'd0;
      compare_q <= 32'hFFFF_FFFF;
      pend_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;
  assign pending = pend_q;

endmodule

// File: rtl/cp0_ext.sv
// Coprocessor 0 beside the M stage: status/cause/EPC state, exception entry, ERET and MFC0/MTC0.
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT  = 6,
  parameter int          TIMER_LINE = 5,
  parameter int          COUNT_DIV  = 1,
  parameter logic [31:0] PRID_VAL   = 32'h1837_3580
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wr_data,
  input  logic                 wr_en,
  input  logic                 m_valid,
  input  logic [31:0]          pc_m,
  input  logic                 bd_m,
  input  logic [4:0]           exc_code,
  input  logic [31:0]          bad_addr,
  input  logic [NUM_HWINT-1:0] hw_int,
  input  logic                 eret,
  output logic [31:0]          rd_data,
  output logic                 take,
  output logic [31:0]          epc,
  output logic                 timer_irq
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] badv_q, badv_d;

  logic [5:0]  hw_ext;
  logic        int_hit, exc_hit;
  logic        wr_ok;
  logic [31:0] pc_base;
  logic [31:0] count, compare;
  logic        pending;
  logic        unused_pc;

  assign hw_ext    = 6'(hw_int);
  assign unused_pc = ^pc_m[1:0];

  always_comb begin
    int_hit = (|(ip_q & im_q)) & ie_q & ~exl_q;
    exc_hit = m_valid & (exc_code != EXC_INT) & ~exl_q;
    take    = ~reset & m_valid & (int_hit | exc_hit);
    // The instruction issuing the MTC0 is the one being flushed, so its write is dropped.
    wr_ok   = wr_en & ~take;
    pc_base = {pc_m[31:2], 2'b00};
  end

  cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
    .clk        (clk),
    .reset      (reset),
    .wr_count   (wr_ok && (wr_addr == CP0_COUNT)),
    .wr_compare (wr_ok && (wr_addr == CP0_COMPARE)),
    .wr_data    (wr_data),
    .count      (count),
    .compare    (compare),
    .pending    (pending)
  );

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    badv_d    = badv_q;
    ip_d      = hw_ext | (6'(pending) << TIMER_LINE);

    if (eret) exl_d = 1'b0;

    if (wr_ok) begin
      case (wr_addr)
        CP0_SR: begin
          im_d  = wr_data[15:10];
          exl_d = wr_data[1];
          ie_d  = wr_data[0];
        end
        CP0_EPC: epc_d = {wr_data[31:2], 2'b00};
        default: ;
      endcase
    end

    if (take) begin
      exl_d     = 1'b1;
      bd_d      = bd_m;
      epc_d     = bd_m ? pc_base - 32'd4 : pc_base;
      exccode_d = int_hit ? EXC_INT : exc_code;
      if (!int_hit && is_addr_exc(exc_code)) badv_d = bad_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q      <= 6'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b1;
      bd_q      <= 1'b0;
      ip_q      <= 6'd0;
      exccode_q <= EXC_INT;
      epc_q     <= 32'd0;
      badv_q    <= 32'd0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
      badv_q    <= badv_d;
    end
  end

  always_comb begin
    case (rd_addr)
      CP0_BADV:    rd_data = badv_q;
      CP0_COUNT:   rd_data = count;
      CP0_COMPARE: rd_data = compare;
      CP0_SR:      rd_data = {16'b0, im_q, 8'b0, exl_q, ie_q};
      CP0_CAUSE:   rd_data = {bd_q, 15'b0, ip_q, 3'b0, exccode_q, 2'b0};
      CP0_EPC:     rd_data = epc_q;
      CP0_PRID:    rd_data = PRID_VAL;
      default:     rd_data = 32'd0;
    endcase
  end

  assign epc       = epc_q;
  assign timer_irq = pending;

endmodule

// File: tb/tb_cp0_ext.sv
// Directed bench for cp0_ext with default parameters; expected values worked out by hand.
module tb_cp0_ext;
  import cp0_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rd_addr, wr_addr, exc_code;
  logic [31:0] wr_data, pc_m, bad_addr;
  logic        wr_en, m_valid, bd_m, eret;
  logic [5:0]  hw_int;
  logic [31:0] rd_data, epc;
  logic        take, timer_irq;

  int n_chk  = 0;
  int n_fail = 0;

  cp0_ext #(
    .NUM_HWINT  (6),
    .TIMER_LINE (5),
    .COUNT_DIV  (1),
    .PRID_VAL   (32'h1837_3580)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .m_valid   (m_valid),
    .pc_m      (pc_m),
    .bd_m      (bd_m),
    .exc_code  (exc_code),
    .bad_addr  (bad_addr),
    .hw_int    (hw_int),
    .eret      (eret),
    .rd_data   (rd_data),
    .take      (take),
    .epc       (epc),
    .timer_irq (timer_irq)
  );

  always #50 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    rd_addr = addr;
    #1;
    chk(tag, rd_data, exp);
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    step();
    wr_en   = 1'b0;
  endtask

  // ERET and an accepted exception can never coincide.
  always @(negedge clk) begin
    if (!reset) begin
      n_chk++;
      assert (!(eret && take)) else begin
        n_fail++;
        $error("FAIL eret_with_take: observed 1 expected 0");
      end
    end
  end

  initial begin
    reset = 1'b1; rd_addr = 5'd0; wr_addr = 5'd0; wr_data = 32'd0; wr_en = 1'b0;
    m_valid = 1'b0; pc_m = 32'd0; bd_m = 1'b0; exc_code = 5'd0; bad_addr = 32'd0;
    hw_int = 6'd0; eret = 1'b0;

    // 1: reset values
    step();
    reset = 1'b0;
    chk("rst_take", take, 32'd0);
    chk("rst_timer_irq", timer_irq, 32'd0);
    chk("rst_epc_port", epc, 32'd0);
    chk_reg("rst_sr", CP0_SR, 32'h0000_0001);
    chk_reg("rst_cause", CP0_CAUSE, 32'd0);
    chk_reg("rst_epc", CP0_EPC, 32'd0);
    chk_reg("rst_prid", CP0_PRID, 32'h1837_3580);
    chk_reg("rst_badv", CP0_BADV, 32'd0);
    chk_reg("rst_compare", CP0_COMPARE, 32'hFFFF_FFFF);
    chk_reg("rst_count", CP0_COUNT, 32'd0);
    chk_reg("unmapped_rd", 5'd3, 32'd0);

    // 2: hardware interrupt on line 0
    hw_int = 6'b000001;
    mtc0(CP0_SR, 32'h0000_0401);
    chk_reg("sr_after_wr", CP0_SR, 32'h0000_0401);
    m_valid = 1'b1; pc_m = 32'h0000_2000;
    #1;
    chk("int_take", take, 32'd1);
    step();
    m_valid = 1'b0;
    chk("int_take_after", take, 32'd0);
    chk_reg("int_cause", CP0_CAUSE, 32'h0000_0400);
    chk_reg("int_sr_exl", CP0_SR, 32'h0000_0403);
    chk_reg("int_epc", CP0_EPC, 32'h0000_2000);
    chk("int_epc_port", epc, 32'h0000_2000);

    // 3: address error in a delay slot
    eret = 1'b1; hw_int = 6'd0;
    step();
    eret = 1'b0;
    chk_reg("eret1_sr", CP0_SR, 32'h0000_0401);
    m_valid = 1'b1; exc_code = EXC_ADEL; bd_m = 1'b1; pc_m = 32'h0000_3004; bad_addr = 32'h0000_1001;
    #1;
    chk("adel_take", take, 32'd1);
    step();
    m_valid = 1'b0; exc_code = 5'd0; bd_m = 1'b0;
    chk_reg("adel_epc", CP0_EPC, 32'h0000_3000);
    chk_reg("adel_cause", CP0_CAUSE, 32'h8000_0010);
    chk_reg("adel_badv", CP0_BADV, 32'h0000_1001);

    // 4: overflow together with an MTC0 to SR; the write is discarded
    eret = 1'b1;
    step();
    eret = 1'b0;
    m_valid = 1'b1; exc_code = EXC_OV; pc_m = 32'h0000_4000;
    wr_en = 1'b1; wr_addr = CP0_SR; wr_data = 32'd0;
    #1;
    chk("ov_take", take, 32'd1);
    step();
    m_valid = 1'b0; exc_code = 5'd0; wr_en = 1'b0;
    chk_reg("ov_sr_kept", CP0_SR, 32'h0000_0403);
    chk_reg("ov_cause", CP0_CAUSE, 32'h0000_0030);
    chk_reg("ov_epc", CP0_EPC, 32'h0000_4000);
    chk_reg("ov_badv_kept", CP0_BADV, 32'h0000_1001);
    wr_en = 1'b1; wr_addr = CP0_EPC; wr_data = 32'h0000_1237;
    chk_reg("epc_no_bypass", CP0_EPC, 32'h0000_4000);
    step();
    wr_en = 1'b0;
    chk_reg("epc_wr_mask", CP0_EPC, 32'h0000_1234);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    chk_reg("cause_ro", CP0_CAUSE, 32'h0000_0030);
    eret = 1'b1;
    step();
    eret = 1'b0;
    chk_reg("eret2_sr", CP0_SR, 32'h0000_0401);

    // 5: timer interrupt on line 5
    mtc0(CP0_SR, 32'h0000_8001);
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    chk_reg("cnt_wr0", CP0_COUNT, 32'd0);
    step(); step(); step(); step();
    chk_reg("cnt_4", CP0_COUNT, 32'd4);
    chk("irq_before", timer_irq, 32'd0);
    step();
    chk_reg("cnt_5", CP0_COUNT, 32'd5);
    chk("irq_at_match", timer_irq, 32'd1);
    chk_reg("cause_ip_lag", CP0_CAUSE, 32'h0000_0030);
    step();
    chk_reg("cause_ip5", CP0_CAUSE, 32'h0000_8030);
    m_valid = 1'b1; pc_m = 32'h0000_5000;
    #1;
    chk("timer_take", take, 32'd1);
    step();
    m_valid = 1'b0;
    chk_reg("timer_cause", CP0_CAUSE, 32'h0000_8000);
    chk_reg("timer_sr", CP0_SR, 32'h0000_8003);
    chk_reg("timer_epc", CP0_EPC, 32'h0000_5000);
    mtc0(CP0_COMPARE, 32'd100);
    chk("irq_cleared", timer_irq, 32'd0);
    chk_reg("compare_100", CP0_COMPARE, 32'd100);
    mtc0(CP0_COUNT, 32'd100);
    chk("cnt_wr_match_noirq", timer_irq, 32'd0);
    step();
    chk_reg("cnt_101", CP0_COUNT, 32'd101);
    chk("irq_after_101", timer_irq, 32'd0);
    mtc0(CP0_COUNT, 32'hFFFF_FFFF);
    chk_reg("cnt_max", CP0_COUNT, 32'hFFFF_FFFF);
    step();
    chk_reg("cnt_wrap", CP0_COUNT, 32'd0);

    // 6: reset while EXL=1 and timer pending
    mtc0(CP0_COUNT, 32'd98);
    step(); step();
    chk("irq_pre_reset", timer_irq, 32'd1);
    chk_reg("sr_pre_reset", CP0_SR, 32'h0000_8003);
    m_valid = 1'b1; exc_code = EXC_OV;
    reset = 1'b1;
    step();
    chk("reset_take", take, 32'd0);
    chk("reset_irq", timer_irq, 32'd0);
    chk("reset_epc_port", epc, 32'd0);
    chk_reg("reset_sr", CP0_SR, 32'h0000_0001);
    chk_reg("reset_cause", CP0_CAUSE, 32'd0);
    chk_reg("reset_epc", CP0_EPC, 32'd0);
    chk_reg("reset_badv", CP0_BADV, 32'd0);
    chk_reg("reset_count", CP0_COUNT, 32'd0);
    chk_reg("reset_compare", CP0_COMPARE, 32'hFFFF_FFFF);
    m_valid = 1'b0; exc_code = 5'd0;
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
